// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer.
// Contents: ALU control codes, R-type funct encodings, and the sequencer state type.
package alu_pkg;

  // ALU control codes (4-bit native width; zero-extended at the top level)
  localparam logic [3:0] CTRL_AND = 4'h0;
  localparam logic [3:0] CTRL_OR  = 4'h1;
  localparam logic [3:0] CTRL_ADD = 4'h2;
  localparam logic [3:0] CTRL_XOR = 4'h3;
  localparam logic [3:0] CTRL_SLL = 4'h4;
  localparam logic [3:0] CTRL_SRL = 4'h5;
  localparam logic [3:0] CTRL_SUB = 4'h6;
  localparam logic [3:0] CTRL_SLT = 4'h7;
  localparam logic [3:0] CTRL_MUL = 4'h8;
  localparam logic [3:0] CTRL_DIV = 4'h9;
  localparam logic [3:0] CTRL_NOR = 4'hC;

  // R-type funct encodings (low six bits)
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_MD   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational ALU control decoder.
// Ports:
//   alu_op   [OP_W]    main-decoder ALU_Op (low two bits select the mode)
//   funct    [FUNCT_W] R-type funct field
//   alu_ctrl [4]       decoded ALU control code
//   illegal            encoding undefined; alu_ctrl falls back to ADD
//   is_md              operation is a multi-cycle multiply/divide
module alu_func_decode
  import alu_pkg::*;
#(
  parameter int OP_W    = 2,
  parameter int FUNCT_W = 6
) (
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         alu_ctrl,
  output logic               illegal,
  output logic               is_md
);

  logic funct_hi_nz;

  // Any set bit above the architected six-bit field makes the funct undefined.
  if (FUNCT_W > 6) begin : g_funct_hi
    assign funct_hi_nz = |funct[FUNCT_W-1:6];
  end else begin : g_no_funct_hi
    assign funct_hi_nz = 1'b0;
  end

  always_comb begin
    alu_ctrl = CTRL_ADD;
    illegal  = 1'b0;
    is_md    = 1'b0;
    case (alu_op[1:0])
      2'b00: alu_ctrl = CTRL_ADD;
      2'b01: alu_ctrl = CTRL_SUB;
      2'b11: alu_ctrl = CTRL_SLT;
      default: begin
        if (funct_hi_nz) begin
          illegal = 1'b1;
        end else begin
          case (funct[5:0])
            FUNCT_ADD: alu_ctrl = CTRL_ADD;
            FUNCT_SUB: alu_ctrl = CTRL_SUB;
            FUNCT_AND: alu_ctrl = CTRL_AND;
            FUNCT_OR:  alu_ctrl = CTRL_OR;
            FUNCT_SLT: alu_ctrl = CTRL_SLT;
            FUNCT_XOR: alu_ctrl = CTRL_XOR;
            FUNCT_NOR: alu_ctrl = CTRL_NOR;
            FUNCT_SLL: alu_ctrl = CTRL_SLL;
            FUNCT_SRL: alu_ctrl = CTRL_SRL;
            FUNCT_MUL: begin
              alu_ctrl = CTRL_MUL;
              is_md    = 1'b1;
            end
            FUNCT_DIV: begin
              alu_ctrl = CTRL_DIV;
              is_md    = 1'b1;
            end
            default:   illegal = 1'b1;
          endcase
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts decode requests, returns a registered ALU control
// result, and stalls for a fixed latency on multiply/divide operations.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   flush                   synchronous abort of all in-flight work
//   in_valid / in_ready     request handshake (alu_op, funct)
//   out_valid / out_ready   result handshake (alu_ctrl, illegal)
//   md_start                one-cycle pulse in the first multiply/divide cycle
//   md_busy                 high for exactly MD_LAT cycles per multiply/divide
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no result held, ready for a request
// ST_HOLD | result presented (out_valid=1)
// ST_MD   | multiply/divide in progress, down-counter running
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int OP_W    = 2,
  parameter int CTRL_W  = 4,
  parameter int MD_LAT  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               illegal,
  output logic               md_start,
  output logic               md_busy
);

  localparam int               CNT_W    = $clog2(MD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  seq_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              illegal_q, illegal_d;
  logic              md_start_q, md_start_d;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_is_md;
  logic       rdy;
  logic       accept;

  alu_func_decode #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal),
    .is_md    (dec_is_md)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_ctrl_d = alu_ctrl_q;
    illegal_d  = illegal_q;
    md_start_d = 1'b0;

    case (state_q)
      ST_IDLE: rdy = 1'b1;
      ST_HOLD: rdy = out_ready;
      default: rdy = 1'b0;
    endcase

    // flush wins over any request presented in the same cycle
    accept = in_valid && rdy && !flush;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_MD: begin
          if (cnt_q == '0) state_d = ST_HOLD;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_HOLD: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: ;
      endcase

      // A new accept overrides the HOLD->IDLE drain, giving back-to-back results.
      if (accept) begin
        alu_ctrl_d = CTRL_W'(dec_ctrl);
        illegal_d  = dec_illegal;
        if (dec_is_md) begin
          state_d    = ST_MD;
          cnt_d      = CNT_LOAD;
          md_start_d = 1'b1;
        end else begin
          state_d = ST_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_ctrl_q <= '0;
      illegal_q  <= 1'b0;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_ctrl_q <= alu_ctrl_d;
      illegal_q  <= illegal_d;
      md_start_q <= md_start_d;
    end
  end

  // Reset leaves the state at IDLE, so in_ready is masked until rst_n releases.
  assign in_ready  = rst_n && rdy;
  assign out_valid = (state_q == ST_HOLD);
  assign md_busy   = (state_q == ST_MD);
  assign md_start  = md_start_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] alu_ctrl;
  logic       illegal;
  logic       md_start;
  logic       md_busy;

  int checks   = 0;
  int failures = 0;
  logic [4:0] sb_q[$];

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .illegal   (illegal),
    .md_start  (md_start),
    .md_busy   (md_busy)
  );

  // Reference decode: {illegal, ctrl}
  function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 5'h02;
      2'b01: return 5'h06;
      2'b11: return 5'h07;
      default: begin
        case (f)
          6'b100000: return 5'h02;
          6'b100010: return 5'h06;
          6'b100100: return 5'h00;
          6'b100101: return 5'h01;
          6'b101010: return 5'h07;
          6'b100110: return 5'h03;
          6'b100111: return 5'h0C;
          6'b000000: return 5'h04;
          6'b000010: return 5'h05;
          6'b011000: return 5'h08;
          6'b011010: return 5'h09;
          default:   return 5'h12;
        endcase
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score the output handshake and record any accept, then advance.
  task automatic tick();
    logic [4:0] e;
    #1;
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'(alu_ctrl), 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("sb_result", {27'd0, illegal, alu_ctrl}, {27'd0, e});
      end
    end
    if (flush) sb_q.delete();
    else if (in_valid && in_ready) sb_q.push_back(model(alu_op, funct));
    @(posedge clk);
    #1;
  endtask

  logic [5:0] b2b_f[4]   = '{6'b100000, 6'b100010, 6'b100101, 6'b101010};
  logic [3:0] b2b_c[4]   = '{4'h2, 4'h6, 4'h1, 4'h7};
  logic [5:0] sweep_f[8] = '{6'b100110, 6'b100111, 6'b000000, 6'b000010,
                             6'b010101, 6'b100100, 6'b111000, 6'b101010};

  initial begin
    int busy_cnt;
    int seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct = 6'd0;

    // reset values
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // AND, latency 1
    alu_op = 2'b10; funct = 6'b100100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("and_out_valid", 32'(out_valid), 32'd1);
    check("and_alu_ctrl", 32'(alu_ctrl), 32'h0);
    check("and_illegal", 32'(illegal), 32'd0);
    tick();
    check("and_drained", 32'(out_valid), 32'd0);

    // MUL: md_start one cycle, md_busy 8 cycles, result at cycle 9
    funct = 6'b011000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mul_md_start_first", 32'(md_start), 32'd1);
    busy_cnt = 0;
    for (int i = 0; i < 12 && md_busy; i++) begin
      busy_cnt++;
      check("mul_in_ready_low", 32'(in_ready), 32'd0);
      if (i > 0) check("mul_md_start_pulse", 32'(md_start), 32'd0);
      tick();
    end
    check("mul_busy_cycles", 32'(busy_cnt), 32'd8);
    check("mul_out_valid", 32'(out_valid), 32'd1);
    check("mul_alu_ctrl", 32'(alu_ctrl), 32'h8);
    tick();

    // four back-to-back accepts
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      funct = b2b_f[i];
      tick();
      check("b2b_out_valid", 32'(out_valid), 32'd1);
      check("b2b_alu_ctrl", 32'(alu_ctrl), 32'(b2b_c[i]));
    end
    in_valid = 1'b0;
    tick();

    // stall with out_ready=0 after OR result
    funct = 6'b100101; in_valid = 1'b1;
    tick();
    out_ready = 1'b0; funct = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_alu_ctrl", 32'(alu_ctrl), 32'h1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", 32'(in_ready), 32'd1);
    tick();

    // illegal funct
    funct = 6'b111111; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ill_alu_ctrl", 32'(alu_ctrl), 32'h2);
    check("ill_illegal", 32'(illegal), 32'd1);
    tick();

    // alu_op modes and a funct sweep, scored through the scoreboard
    in_valid = 1'b1;
    alu_op = 2'b00; tick();
    alu_op = 2'b01; tick();
    alu_op = 2'b11; tick();
    alu_op = 2'b10;
    for (int i = 0; i < 8; i++) begin
      funct = sweep_f[i];
      tick();
    end
    in_valid = 1'b0;
    tick();

    // flush in MD cycle 3
    funct = 6'b011010; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("flush_pre_busy", 32'(md_busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_md_busy", 32'(md_busy), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("flush_no_result", 32'(seen), 32'd0);

    // flush beats a simultaneous request
    funct = 6'b100000; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_prio_out_valid", 32'(out_valid), 32'd0);

    // reset mid-MD
    funct = 6'b011000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    check("rstmd_out_valid", 32'(out_valid), 32'd0);
    check("rstmd_md_busy", 32'(md_busy), 32'd0);
    check("rstmd_md_start", 32'(md_start), 32'd0);
    check("rstmd_alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("rstmd_illegal", 32'(illegal), 32'd0);
    check("rstmd_in_ready", 32'(in_ready), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rstmd_release_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid || md_busy) seen++;
      tick();
    end
    check("rstmd_no_result", 32'(seen), 32'd0);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
